// File: rtl/fifo_wr_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_wr_arb_pkg
//   Shared definitions for the FIFO write arbiter:
//     state_e    - arbiter state encoding (IDLE = 0, BURST = 1)
//     STAT_WIDTH - width of each per-requester beat counter (optional stats)
//     gid_width  - width of a requester index for a given requester count
// -----------------------------------------------------------------------------
package fifo_wr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int STAT_WIDTH = 16;

  // Width of a requester index; never less than one bit.
  function automatic int gid_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr.sv
// -----------------------------------------------------------------------------
// fifo_wr_arb_rr
//   Combinational round-robin pick: returns the first set bit of valid_i
//   strictly after last_idx_i, wrapping modulo NREQ. last_idx_i itself is
//   considered last, so a lone requester can win again.
//
//   Ports
//     valid_i    [NREQ-1:0] request vector
//     last_idx_i [GW-1:0]   index granted most recently
//     found_o               at least one request is pending
//     index_o    [GW-1:0]   winning index (0 when found_o is low)
// -----------------------------------------------------------------------------
module fifo_wr_arb_rr
  import fifo_wr_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int GW   = gid_width(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [GW-1:0]   last_idx_i,
  output logic            found_o,
  output logic [GW-1:0]   index_o
);

  int          cand;
  logic [GW-1:0] cand_idx;

  // NOTE: every output of a combinational block gets a default first so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    found_o  = 1'b0;
    index_o  = '0;
    cand     = 0;
    cand_idx = '0;
    // Scan from the farthest candidate to the nearest; the nearest valid one
    // is written last and therefore wins.
    for (int k = NREQ; k >= 1; k--) begin
      cand     = (int'(last_idx_i) + k) % NREQ;
      cand_idx = cand[GW-1:0];
      if (valid_i[cand_idx]) begin
        found_o = 1'b1;
        index_o = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// -----------------------------------------------------------------------------
// fifo_wr_arb
//   Round-robin arbiter that lets NREQ requesters write bursts into a single
//   FIFO. In IDLE it waits for a pending request and at least MIN_FREE free
//   FIFO slots, registers the winner and enters BURST. In BURST the grant
//   holder's valid/ready handshake is passed straight to the FIFO write port
//   until a beat carrying req_last is accepted. No pre-emption, no timeout.
//
//   Ports
//     clk, rst_n            clock, asynchronous active-low reset
//     req_valid/req_last    per-requester handshake and end-of-burst marker
//     req_data              requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//     req_ready             only the grant holder's bit can be high
//     fifo_din, fifo_wr_en  FIFO write port
//     fifo_full             FIFO full flag (stalls the burst)
//     fifo_elemcnt          FIFO occupancy, used for the free-space test
//     grant_id              index of the current / most recent grant holder
//     busy                  high while in BURST
//     stat_beats            per-requester saturating accepted-beat counters,
//                           present only when FIFO_WR_ARB_STATS_EN is defined
// -----------------------------------------------------------------------------
module fifo_wr_arb
  import fifo_wr_arb_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 72,
  parameter int ADDR_WIDTH = 6,
  parameter int MIN_FREE   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ-1:0]              req_last,
  input  logic [NREQ*DATA_WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]              req_ready,
  output logic [DATA_WIDTH-1:0]        fifo_din,
  output logic                         fifo_wr_en,
  input  logic                         fifo_full,
  input  logic [ADDR_WIDTH-1:0]        fifo_elemcnt,
  output logic [gid_width(NREQ)-1:0]   grant_id,
  output logic                         busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NREQ*STAT_WIDTH-1:0]   stat_beats
`endif
);

  localparam int GW = gid_width(NREQ);
  localparam logic [ADDR_WIDTH:0] DEPTH_M1   = (ADDR_WIDTH+1)'((1 << ADDR_WIDTH) - 1);
  localparam logic [ADDR_WIDTH:0] MIN_FREE_W = (ADDR_WIDTH+1)'(MIN_FREE);

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_q,  last_d;

  logic [ADDR_WIDTH:0] free_slots;
  logic                rr_found;
  logic [GW-1:0]       rr_index;

  // One extra bit keeps the subtraction unsigned and wrap-free.
  assign free_slots = DEPTH_M1 - {1'b0, fifo_elemcnt};

  fifo_wr_arb_rr #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_rr (
    .valid_i    (req_valid),
    .last_idx_i (last_q),
    .found_o    (rr_found),
    .index_o    (rr_index)
  );

  // ---------------------------------------------------------------------------
  // Datapath: purely combinational from the registered grant.
  // ---------------------------------------------------------------------------
  assign busy       = (state_q == BURST);
  assign grant_id   = grant_q;
  assign fifo_wr_en = busy & req_valid[grant_q] & ~fifo_full;
  assign fifo_din   = req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    req_ready          = '0;
    req_ready[grant_q] = busy & ~fifo_full;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (rr_found && (free_slots >= MIN_FREE_W)) begin
          grant_d = rr_index;
          state_d = BURST;
        end
      end
      BURST: begin
        // The burst ends only on an accepted last beat; a silent holder keeps
        // the grant indefinitely.
        if (fifo_wr_en && req_last[grant_q]) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(NREQ - 1);  // requester 0 wins the first arbitration
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  // ---------------------------------------------------------------------------
  // Per-requester accepted-beat counters, saturating at all-ones.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NREQ; g++) begin : g_stats
    logic [STAT_WIDTH-1:0] cnt_q;

    // NOTE: these counters are software-visible state, so unlike a data
    // storage array they are cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (fifo_wr_en && (grant_q == GW'(g)) && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign stat_beats[g*STAT_WIDTH +: STAT_WIDTH] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arb
//   Self-checking bench for fifo_wr_arb with default parameters.
//   Inputs are driven 1 time unit after the rising edge; outputs are sampled
//   on the falling edge. Phases: reset values, a table of cycle vectors,
//   hand-written multi-cycle sequences (stall, fairness, reset mid-burst) and
//   a randomized run against an owner/round-robin reference model.
//   Define FIFO_WR_ARB_STATS_EN to also check the beat counters.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arb;

  localparam int NREQ     = 4;
  localparam int DW       = 72;
  localparam int AW       = 6;
  localparam int MIN_FREE = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_last = '0;
  logic [NREQ*DW-1:0]   req_data = '0;
  logic [NREQ-1:0]      req_ready;
  logic [DW-1:0]        fifo_din;
  logic                 fifo_wr_en;
  logic                 fifo_full = 1'b0;
  logic [AW-1:0]        fifo_elemcnt = '0;
  logic [1:0]           grant_id;
  logic                 busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [NREQ*16-1:0]   stat_beats;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_wr_arb #(
    .NREQ       (NREQ),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MIN_FREE   (MIN_FREE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_din     (fifo_din),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_full    (fifo_full),
    .fifo_elemcnt (fifo_elemcnt),
    .grant_id     (grant_id),
    .busy         (busy)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stat_beats   (stat_beats)
`endif
  );

  typedef struct {
    logic [3:0] valid;
    logic [3:0] last;
    logic       full;
    logic [5:0] elemcnt;
    logic       busy;
    logic [3:0] ready;
    logic       wr;
    logic [1:0] gid;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input int req, input int n);
    return {8'(req), 64'(n)};
  endfunction

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic f,
                              input logic [5:0] e, input logic b, input logic [3:0] r,
                              input logic w, input logic [1:0] g);
    vec_t t;
    t.valid = v; t.last = l; t.full = f; t.elemcnt = e;
    t.busy = b; t.ready = r; t.wr = w; t.gid = g;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at rising edge + 1 with reset just released.
  task automatic apply_reset();
    rst_n        = 1'b0;
    req_valid    = '0;
    req_last     = '0;
    fifo_full    = 1'b0;
    fifo_elemcnt = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic load_fixed_data();
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = word_of(i, 'h55 + i);
  endtask

  // Reference model state for the random phase.
  int owner;
  int last_g;
  int exp_gid;
  int wn[NREQ];
  int idx[NREQ];
  int blen[NREQ];
  int beats[NREQ];

  initial begin
    int nwr;
    int stalls;
    int k;
    int gq[$];
    int per_req[NREQ];
    logic [3:0] exp_ready;
    logic       exp_wr;
    int         free_slots;
    int         pos;

    // ------------------------------------------------------------ reset state
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    load_fixed_data();
    @(negedge clk);
    check("reset.busy", 128'(busy), 128'(0));
    check("reset.ready", 128'(req_ready), 128'(0));
    check("reset.wr_en", 128'(fifo_wr_en), 128'(0));
    check("reset.grant_id", 128'(grant_id), 128'(0));
    apply_reset();

    // ----------------------------------------------------- table-driven cycles
    //                valid    last     f   elem  busy ready    wr  gid
    tbl.push_back(mk(4'b0101, 4'b1111, 0, 6'd0,  0, 4'b0000, 0, 2'd0));
    tbl.push_back(mk(4'b0101, 4'b1111, 0, 6'd0,  1, 4'b0001, 1, 2'd0));
    tbl.push_back(mk(4'b0101, 4'b1111, 0, 6'd0,  0, 4'b0000, 0, 2'd0));
    tbl.push_back(mk(4'b0101, 4'b1111, 0, 6'd0,  1, 4'b0100, 1, 2'd2));
    tbl.push_back(mk(4'b0101, 4'b1111, 0, 6'd0,  0, 4'b0000, 0, 2'd2));
    tbl.push_back(mk(4'b0101, 4'b1111, 0, 6'd0,  1, 4'b0001, 1, 2'd0));
    tbl.push_back(mk(4'b0101, 4'b1111, 0, 6'd0,  0, 4'b0000, 0, 2'd0));
    tbl.push_back(mk(4'b0101, 4'b1111, 0, 6'd0,  1, 4'b0100, 1, 2'd2));
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 6'd0,  0, 4'b0000, 0, 2'd2));
    // free = 3 < MIN_FREE: no grant; free = 4: grant next cycle
    tbl.push_back(mk(4'b0010, 4'b0010, 0, 6'd60, 0, 4'b0000, 0, 2'd2));
    tbl.push_back(mk(4'b0010, 4'b0010, 0, 6'd60, 0, 4'b0000, 0, 2'd2));
    tbl.push_back(mk(4'b0010, 4'b0010, 0, 6'd59, 0, 4'b0000, 0, 2'd2));
    tbl.push_back(mk(4'b0010, 4'b0010, 0, 6'd59, 1, 4'b0010, 1, 2'd1));
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 6'd0,  0, 4'b0000, 0, 2'd1));
    // full FIFO blocks grant; holder dropping valid keeps grant; stall on full
    tbl.push_back(mk(4'b1000, 4'b1000, 0, 6'd63, 0, 4'b0000, 0, 2'd1));
    tbl.push_back(mk(4'b1000, 4'b1000, 0, 6'd0,  0, 4'b0000, 0, 2'd1));
    tbl.push_back(mk(4'b0000, 4'b1000, 0, 6'd0,  1, 4'b1000, 0, 2'd3));
    tbl.push_back(mk(4'b0001, 4'b0001, 0, 6'd0,  1, 4'b1000, 0, 2'd3));
    tbl.push_back(mk(4'b1000, 4'b1000, 1, 6'd0,  1, 4'b0000, 0, 2'd3));
    tbl.push_back(mk(4'b1000, 4'b1000, 0, 6'd0,  1, 4'b1000, 1, 2'd3));
    tbl.push_back(mk(4'b0001, 4'b0001, 0, 6'd0,  0, 4'b0000, 0, 2'd3));
    tbl.push_back(mk(4'b0001, 4'b0001, 0, 6'd0,  1, 4'b0001, 1, 2'd0));
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 6'd0,  0, 4'b0000, 0, 2'd0));

    for (int i = 0; i < tbl.size(); i++) begin
      req_valid    = tbl[i].valid;
      req_last     = tbl[i].last;
      fifo_full    = tbl[i].full;
      fifo_elemcnt = tbl[i].elemcnt;
      @(negedge clk);
      check($sformatf("tbl[%0d].busy", i), 128'(busy), 128'(tbl[i].busy));
      check($sformatf("tbl[%0d].ready", i), 128'(req_ready), 128'(tbl[i].ready));
      check($sformatf("tbl[%0d].wr_en", i), 128'(fifo_wr_en), 128'(tbl[i].wr));
      check($sformatf("tbl[%0d].grant_id", i), 128'(grant_id), 128'(tbl[i].gid));
      if (tbl[i].wr)
        check($sformatf("tbl[%0d].din", i), 128'(fifo_din), 128'(word_of(int'(tbl[i].gid), 'h55 + int'(tbl[i].gid))));
      tick();
    end

    // ------------------------------------- 3-word burst with 2 full cycles
    // last granted is 0 here, only requester 1 is valid.
    k = 0; nwr = 0; stalls = 0;
    for (int c = 0; c < 8; c++) begin
      req_valid = (k < 3) ? 4'b0010 : 4'b0000;
      req_last  = (k == 2) ? 4'b0010 : 4'b0000;
      req_data[1*DW +: DW] = word_of(1, 'h100 + k);
      fifo_full = (c == 2) || (c == 3);
      @(negedge clk);
      if (c == 1) check("stall.grant_id", 128'(grant_id), 128'(1));
      if (busy && !fifo_wr_en) stalls++;
      if (fifo_wr_en) begin
        check($sformatf("stall.din[%0d]", nwr), 128'(fifo_din), 128'(word_of(1, 'h100 + nwr)));
        nwr++;
      end
      if (req_valid[1] && req_ready[1]) k++;
      tick();
    end
    fifo_full = 1'b0;
    check("stall.writes", 128'(nwr), 128'(3));
    check("stall.wr_low_cycles", 128'(stalls), 128'(2));

    // ------------------------------------- reset during 2nd beat of a burst
    // last granted is 1 here; without reset, all-valid would next grant 2.
    req_valid = 4'b0001;
    req_last  = 4'b0000;
    req_data[0 +: DW] = word_of(0, 'h200);
    @(negedge clk);
    check("rstmid.idle", 128'(busy), 128'(0));
    tick();
    @(negedge clk);
    check("rstmid.beat0_wr", 128'(fifo_wr_en), 128'(1));
    tick();
    req_data[0 +: DW] = word_of(0, 'h201);
    #1;
    check("rstmid.beat1_busy", 128'(busy), 128'(1));
    rst_n = 1'b0;
    #1;
    check("rstmid.busy", 128'(busy), 128'(0));
    check("rstmid.ready", 128'(req_ready), 128'(0));
    check("rstmid.wr_en", 128'(fifo_wr_en), 128'(0));
    check("rstmid.grant_id", 128'(grant_id), 128'(0));
    tick();
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    load_fixed_data();
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid.post_idle", 128'(busy), 128'(0));
    tick();
    @(negedge clk);
    check("rstmid.post_grant", 128'(grant_id), 128'(0));
    check("rstmid.post_ready", 128'(req_ready), 128'(4'b0001));
    tick();

    // ------------------------------------- fairness, all valid, 1-word bursts
    apply_reset();
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    for (int i = 0; i < NREQ; i++) per_req[i] = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (fifo_wr_en) gq.push_back(int'(grant_id));
      tick();
    end
    check("fair.beats", 128'(gq.size()), 128'(8));
    for (int i = 0; i < gq.size(); i++) begin
      check($sformatf("fair.order[%0d]", i), 128'(gq[i]), 128'(i % NREQ));
      if (gq[i] >= 0 && gq[i] < NREQ) per_req[gq[i]]++;
    end
    for (int i = 0; i < NREQ; i++)
      check($sformatf("fair.share[%0d]", i), 128'(per_req[i]), 128'(2));

    // ------------------------------------- randomized run vs reference model
    apply_reset();
    owner = -1; last_g = NREQ - 1; exp_gid = 0;
    for (int i = 0; i < NREQ; i++) begin
      wn[i] = 0; idx[i] = 0; blen[i] = $urandom_range(1, 4); beats[i] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = ($urandom_range(0, 9) < 7);
        req_last[i]  = (idx[i] == blen[i] - 1);
        req_data[i*DW +: DW] = word_of(i, wn[i]);
      end
      fifo_full    = ($urandom_range(0, 4) == 0);
      fifo_elemcnt = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(57, 63))
                                                 : 6'($urandom_range(0, 20));
      @(negedge clk);
      exp_ready = '0;
      exp_wr    = 1'b0;
      if (owner >= 0) begin
        pos = owner;
        exp_ready[pos[1:0]] = !fifo_full;
        exp_wr = req_valid[pos[1:0]] && !fifo_full;
      end
      check($sformatf("rand[%0d].busy", c), 128'(busy), 128'(owner >= 0));
      check($sformatf("rand[%0d].ready", c), 128'(req_ready), 128'(exp_ready));
      check($sformatf("rand[%0d].wr_en", c), 128'(fifo_wr_en), 128'(exp_wr));
      check($sformatf("rand[%0d].grant_id", c), 128'(grant_id), 128'(exp_gid));
      if (exp_wr)
        check($sformatf("rand[%0d].din", c), 128'(fifo_din), 128'(word_of(owner, wn[owner])));
      // requester side: advance on handshake
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && exp_ready[i]) begin
          wn[i]++;
          idx[i]++;
          beats[i]++;
          if (idx[i] == blen[i]) begin
            idx[i]  = 0;
            blen[i] = $urandom_range(1, 4);
          end
        end
      end
      // arbiter side: what the next cycle should look like
      if (owner < 0) begin
        free_slots = (1 << AW) - 1 - int'(fifo_elemcnt);
        if (req_valid != '0 && free_slots >= MIN_FREE) begin
          for (int s = 1; s <= NREQ; s++) begin
            pos = (last_g + s) % NREQ;
            if (owner < 0 && req_valid[pos[1:0]]) begin
              owner   = pos;
              exp_gid = pos;
            end
          end
        end
      end else if (exp_wr && req_last[pos[1:0]]) begin
        last_g = owner;
        owner  = -1;
      end
      tick();
    end

`ifdef FIFO_WR_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++)
      check($sformatf("stats.rand[%0d]", i), 128'(stat_beats[i*16 +: 16]), 128'(beats[i]));

    // 70000+ beats from requester 3 in one long burst: counter saturates
    apply_reset();
    req_valid = 4'b1000;
    req_last  = 4'b0000;
    repeat (70003) @(posedge clk);
    #1;
    @(negedge clk);
    check("stats.sat[3]", 128'(stat_beats[48 +: 16]), 128'(16'hFFFF));
    for (int i = 0; i < 3; i++)
      check($sformatf("stats.sat[%0d]", i), 128'(stat_beats[i*16 +: 16]), 128'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters, 2..8.
REQ-002 SHALL have parameter DATA_WIDTH, default 72: word width, equal to the FIFO width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 6: FIFO address width.
REQ-004 SHALL have parameter MIN_FREE, default 4: free FIFO slots required to start a burst, 1..2^ADDR_WIDTH-1.
REQ-005 SHALL have port clk, input, 1: the only clock; all state on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port req_valid, input, NREQ: per-requester word valid.
REQ-008 SHALL have port req_last, input, NREQ: marks the final word of a burst.
REQ-009 SHALL have port req_data, input, NREQ*DATA_WIDTH: requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port req_ready, output, NREQ: word accepted when valid and ready are both high.
REQ-011 SHALL have port fifo_din, output, DATA_WIDTH: FIFO write data.
REQ-012 SHALL have port fifo_wr_en, output, 1: FIFO write enable.
REQ-013 SHALL have port fifo_full, input, 1: FIFO full flag.
REQ-014 SHALL have port fifo_elemcnt, input, ADDR_WIDTH: FIFO occupancy.
REQ-015 SHALL have port grant_id, output, clog2(NREQ): index of the current grant holder.
REQ-016 SHALL have port busy, output, 1: high while in state BURST.

Function
REQ-017 SHALL implement two states: IDLE and BURST.
REQ-018 In IDLE, SHALL compute free = 2^ADDR_WIDTH-1-fifo_elemcnt, ADDR_WIDTH+1 bits unsigned, no wrap.
REQ-019 In IDLE, if any req_valid is high and free >= MIN_FREE, SHALL register grant_id as the first valid index after the last granted index, wrapping modulo NREQ, and enter BURST next cycle.
REQ-020 In IDLE, req_ready and fifo_wr_en SHALL be 0; the arbitration latency is one cycle.
REQ-021 In BURST, SHALL drive req_ready[grant_id] = !fifo_full and all other req_ready bits 0, combinationally.
REQ-022 SHALL drive fifo_wr_en = busy & req_valid[grant_id] & !fifo_full, and fifo_din = req_data slice of grant_id, combinationally.
REQ-023 On an accepted beat with req_last high, SHALL return to IDLE, record grant_id as last granted, and hold at least one IDLE cycle between bursts.
REQ-024 A grant holder deasserting req_valid mid-burst SHALL keep the grant; there is no timeout and no pre-emption.
REQ-025 When fifo_full is high, SHALL stall with no beat lost or duplicated.
REQ-026 A single-word burst (valid and last on the same beat) SHALL be legal.
REQ-027 In IDLE, grant_id SHALL hold its last value.

Reset
REQ-028 While rst_n is low, SHALL force state IDLE, grant_id 0, last granted NREQ-1 so requester 0 wins first, busy 0, req_ready 0, fifo_wr_en 0.
REQ-029 Reset asserted mid-burst SHALL abort the burst immediately; the partial burst is not completed.

Configuration
REQ-030 With FIFO_WR_ARB_STATS_EN defined, SHALL add output stat_beats, NREQ*16 bits: per-requester accepted-beat counters, saturating at 0xFFFF, cleared by reset.
REQ-031 Without FIFO_WR_ARB_STATS_EN defined, stat_beats and its counters SHALL be absent; all other behaviour is unchanged.

Structure
REQ-032 Package fifo_wr_arb_pkg SHALL hold the state encoding (IDLE=0, BURST=1) and the grant-id width function.
REQ-033 The round-robin pick SHALL be a combinational sub-module fifo_wr_arb_rr (inputs: valid vector, last index; outputs: found, index).

Verification
REQ-034 Reset, then req_valid=4'b0101 with last on each beat -> grants 0,2,0,2; each burst one word; one idle cycle between bursts.
REQ-035 Requester 1 bursts 3 words, fifo_full asserted for 2 cycles mid-burst -> fifo_wr_en low for 2 cycles; exactly 3 writes in order.
REQ-036 fifo_elemcnt=60, MIN_FREE=4, ADDR_WIDTH=6 (free=3) -> no grant; elemcnt=59 -> grant the next cycle.
REQ-037 All four valid continuously, single-word bursts -> grant order 0,1,2,3,0; each requester gets 25% of beats.
REQ-038 rst_n low during the second beat of a 4-word burst -> busy=0 and req_ready=0 immediately; after release, requester 0 wins first.
REQ-039 With FIFO_WR_ARB_STATS_EN, 70000 beats from requester 3 -> stat_beats[63:48]=0xFFFF; other counters 0.
